trace_stream_tx: RTL and testbench

- Consumes the per-instruction retire-trace records the write-back stage emits on its log_trace_i strobe.
- Buffers them in a small FIFO and serialises each record as a variable-length burst of 32-bit words on a valid/ready stream.
- Gives synthesizable hardware the trace channel that simulation gets through DPI; drives an off-core debug/trace sink.
- Lossy by design: records arriving while the FIFO is full are dropped and counted.

---
 rtl/trace_stream_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_trace_stream_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_tx.sv
// Retire-trace serialiser: buffers write-back trace records in a small FIFO and
// emits each one as a 4/6/8/10-word burst on a 32-bit valid/ready stream.
module trace_stream_tx #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   log_trace_i,
    input  logic [ADDR_WIDTH-1:0]  pc_log_i,
    input  logic [INSTR_WIDTH-1:0] instruction_log_i,
    input  logic [DATA_WIDTH-1:0]  reg_val_i,
    input  logic [REG_ADDR_W-1:0]  rd_addr_i,
    input  logic                   reg_we_i,
    input  logic                   mem_access_log_i,
    input  logic                   mem_we_log_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_log_i,
    input  logic [DATA_WIDTH-1:0]  mem_write_data_log_i,
    output logic [31:0]            trace_data_o,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output logic                   trace_last_o,
    output logic [15:0]            drop_count_o,
    output logic                   idle_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0]             seq;
        logic                   drop_flag;
        logic [REG_ADDR_W-1:0]  rd_addr;
        logic                   reg_we;
        logic                   mem_access;
        logic                   mem_we;
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  reg_val;
        logic [ADDR_WIDTH-1:0]  mem_addr;
        logic [DATA_WIDTH-1:0]  mem_data;
    } rec_t;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_INSTR, S_PC_LO, S_PC_HI,
        S_REG_LO, S_REG_HI, S_MA_LO, S_MA_HI, S_MD_LO, S_MD_HI
    } state_t;

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    rec_t             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       seq_r;
    logic             drop_flag_r;
    logic [15:0]      drop_count_r;
    state_t           state_r;
    state_t           state_next_s;
    rec_t             rec_in_s;
    rec_t             head_s;
    logic             hs_s;
    logic             last_s;
    logic             pop_s;
    logic             push_s;
    logic             more_s;
    logic [3:0]       word_cnt_s;
    logic [31:0]      data_s;

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];
    assign head_s  = fifo_mem_r[rd_ptr_r];
    assign hs_s    = trace_valid_o && trace_ready_i;
    assign pop_s   = hs_s && last_s;
    // A full FIFO still takes a record when its head leaves in the same cycle
    assign push_s  = log_trace_i && ((count_r < CNT_W'(FIFO_DEPTH)) || pop_s);
    assign more_s  = (count_r > CNT_W'(1'b1)) || push_s;

    // Assemble the incoming record together with its sequence tag
    always_comb begin
        rec_in_s            = '0;
        rec_in_s.seq        = seq_r;
        rec_in_s.drop_flag  = drop_flag_r;
        rec_in_s.rd_addr    = rd_addr_i;
        rec_in_s.reg_we     = reg_we_i;
        rec_in_s.mem_access = mem_access_log_i;
        rec_in_s.mem_we     = mem_we_log_i;
        rec_in_s.instr      = instruction_log_i;
        rec_in_s.pc         = pc_log_i;
        rec_in_s.reg_val    = reg_val_i;
        rec_in_s.mem_addr   = mem_addr_log_i;
        rec_in_s.mem_data   = mem_write_data_log_i;
    end

    // Record storage
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rec_in_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, sequence tag and drop accounting
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            seq_r        <= 8'd0;
            drop_flag_r  <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r    <= wr_ptr_r + PTR_W'(1'b1);
                seq_r       <= seq_r + 8'd1;
                drop_flag_r <= 1'b0;
            end else if (log_trace_i) begin
                drop_flag_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serialiser state register
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next word selection; absent groups are skipped outright
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if ((count_r != '0) || push_s) state_next_s = S_HDR;
                else                           state_next_s = S_IDLE;
            end
            S_HDR:    if (hs_s) state_next_s = S_INSTR;  else state_next_s = state_r;
            S_INSTR:  if (hs_s) state_next_s = S_PC_LO;  else state_next_s = state_r;
            S_PC_LO:  if (hs_s) state_next_s = S_PC_HI;  else state_next_s = state_r;
            S_PC_HI: begin
                if (!hs_s)                  state_next_s = state_r;
                else if (head_s.reg_we)     state_next_s = S_REG_LO;
                else if (head_s.mem_access) state_next_s = S_MA_LO;
                else if (more_s)            state_next_s = S_HDR;
                else                        state_next_s = S_IDLE;
            end
            S_REG_LO: if (hs_s) state_next_s = S_REG_HI; else state_next_s = state_r;
            S_REG_HI: begin
                if (!hs_s)                  state_next_s = state_r;
                else if (head_s.mem_access) state_next_s = S_MA_LO;
                else if (more_s)            state_next_s = S_HDR;
                else                        state_next_s = S_IDLE;
            end
            S_MA_LO:  if (hs_s) state_next_s = S_MA_HI;  else state_next_s = state_r;
            S_MA_HI:  if (hs_s) state_next_s = S_MD_LO;  else state_next_s = state_r;
            S_MD_LO:  if (hs_s) state_next_s = S_MD_HI;  else state_next_s = state_r;
            S_MD_HI: begin
                if (!hs_s)       state_next_s = state_r;
                else if (more_s) state_next_s = S_HDR;
                else             state_next_s = S_IDLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    assign word_cnt_s = 4'd4 + {2'b00, head_s.reg_we, 1'b0} + {1'b0, head_s.mem_access, 2'b00};

    // Word multiplexer and end-of-record flag, driven only by registered state
    always_comb begin
        data_s = 32'd0;
        last_s = 1'b0;
        case (state_r)
            S_HDR:    data_s = {head_s.seq, head_s.rd_addr, head_s.reg_we, head_s.mem_access,
                                head_s.mem_we, head_s.drop_flag, 11'd0, word_cnt_s};
            S_INSTR:  data_s = head_s.instr;
            S_PC_LO:  data_s = head_s.pc[31:0];
            S_PC_HI: begin
                data_s = head_s.pc[63:32];
                last_s = !head_s.reg_we && !head_s.mem_access;
            end
            S_REG_LO: data_s = head_s.reg_val[31:0];
            S_REG_HI: begin
                data_s = head_s.reg_val[63:32];
                last_s = !head_s.mem_access;
            end
            S_MA_LO:  data_s = head_s.mem_addr[31:0];
            S_MA_HI:  data_s = head_s.mem_addr[63:32];
            S_MD_LO:  data_s = head_s.mem_we ? head_s.mem_data[31:0] : 32'd0;
            S_MD_HI: begin
                data_s = head_s.mem_we ? head_s.mem_data[63:32] : 32'd0;
                last_s = 1'b1;
            end
            default: begin
                data_s = 32'd0;
                last_s = 1'b0;
            end
        endcase
    end

    assign trace_data_o  = data_s;
    assign trace_last_o  = last_s;
    assign trace_valid_o = (state_r != S_IDLE);
    assign drop_count_o  = drop_count_r;
    assign idle_o        = (count_r == '0) && (state_r == S_IDLE);

endmodule

// File: tb/tb_trace_stream_tx.sv
// Directed bench for trace_stream_tx: table of single records plus sequences for
// back-pressure, overflow/drop, push-on-pop, long back-to-back runs and mid-burst reset.
module tb_trace_stream_tx;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        log_trace_i;
    logic [63:0] pc_log_i;
    logic [31:0] instruction_log_i;
    logic [63:0] reg_val_i;
    logic [4:0]  rd_addr_i;
    logic        reg_we_i;
    logic        mem_access_log_i;
    logic        mem_we_log_i;
    logic [63:0] mem_addr_log_i;
    logic [63:0] mem_write_data_log_i;
    logic [31:0] trace_data_o;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic        trace_last_o;
    logic [15:0] drop_count_o;
    logic        idle_o;

    trace_stream_tx dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .log_trace_i(log_trace_i),
        .pc_log_i(pc_log_i), .instruction_log_i(instruction_log_i),
        .reg_val_i(reg_val_i), .rd_addr_i(rd_addr_i), .reg_we_i(reg_we_i),
        .mem_access_log_i(mem_access_log_i), .mem_we_log_i(mem_we_log_i),
        .mem_addr_log_i(mem_addr_log_i), .mem_write_data_log_i(mem_write_data_log_i),
        .trace_data_o(trace_data_o), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_last_o(trace_last_o),
        .drop_count_o(drop_count_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             we, ma, mw;
        logic [4:0]       rd;
        logic [63:0]      pc, val, maddr, mdata;
        logic [31:0]      instr;
        int               n;
        logic [9:0][31:0] w;
    } vec_t;

    vec_t        vecs [4];
    vec_t        vs;
    logic [31:0] got_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic vec_t mk(input logic we, input logic ma, input logic mw, input logic [4:0] rd,
                                input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] val,
                                input logic [63:0] maddr, input logic [63:0] mdata, input int n);
        vec_t v;
        v.we = we; v.ma = ma; v.mw = mw; v.rd = rd; v.pc = pc; v.instr = instr;
        v.val = val; v.maddr = maddr; v.mdata = mdata; v.n = n; v.w = '0;
        return v;
    endfunction

    task automatic drive_rec(input vec_t v);
        log_trace_i = 1'b1; pc_log_i = v.pc; instruction_log_i = v.instr; reg_val_i = v.val;
        rd_addr_i = v.rd; reg_we_i = v.we; mem_access_log_i = v.ma; mem_we_log_i = v.mw;
        mem_addr_log_i = v.maddr; mem_write_data_log_i = v.mdata;
    endtask

    task automatic plain_rec(input logic [63:0] pc);
        drive_rec(mk(1'b0, 1'b0, 1'b0, 5'd0, pc, 32'h0000_0013, 64'd0, 64'd0, 64'd0, 4));
    endtask

    task automatic collect(input int max_cyc);
        bit done;
        done = 1'b0;
        got_q.delete();
        for (int c = 0; c < max_cyc && !done; c++) begin
            if (trace_valid_o && trace_ready_i) begin
                got_q.push_back(trace_data_o);
                if (trace_last_o) done = 1'b1;
            end
            step();
        end
        if (!done) check("collect_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_words(input string name, input vec_t v);
        check({name, "_nwords"}, 64'(got_q.size()), 64'(v.n));
        for (int i = 0; i < v.n; i++) begin
            check($sformatf("%s_w%0d", name, i), (i < got_q.size()) ? {32'd0, got_q[i]} : 64'hx, {32'd0, v.w[i]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_d;
        logic        hold_l;
        bit          done;
        int          bubbles;
        int          words;
        int          last_err;
        logic [63:0] exp_pc [5];

        // Hand-computed record table
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'h0000_0000_8000_0000, 32'h0000_0013, 64'd0, 64'd0, 64'd0, 4);
        vecs[0].w[0] = 32'h0000_0004; vecs[0].w[1] = 32'h0000_0013;
        vecs[0].w[2] = 32'h8000_0000; vecs[0].w[3] = 32'h0000_0000;
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 5'd5, 64'h0000_0000_0000_1000, 32'h0000_0033,
                     64'h1122_3344_5566_7788, 64'h10, 64'hAB, 10);
        vecs[1].w[0] = 32'h012F_000A; vecs[1].w[1] = 32'h0000_0033; vecs[1].w[2] = 32'h0000_1000;
        vecs[1].w[3] = 32'h0000_0000; vecs[1].w[4] = 32'h5566_7788; vecs[1].w[5] = 32'h1122_3344;
        vecs[1].w[6] = 32'h0000_0010; vecs[1].w[7] = 32'h0000_0000; vecs[1].w[8] = 32'h0000_00AB;
        vecs[1].w[9] = 32'h0000_0000;
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_0000_0004, 32'hDEAD_BEEF,
                     64'hCAFE_BABE_1234_5678, 64'd0, 64'd0, 6);
        vecs[2].w[0] = 32'h02FC_0006; vecs[2].w[1] = 32'hDEAD_BEEF; vecs[2].w[2] = 32'h0000_0004;
        vecs[2].w[3] = 32'hFFFF_FFFF; vecs[2].w[4] = 32'h1234_5678; vecs[2].w[5] = 32'hCAFE_BABE;
        vecs[3] = mk(1'b0, 1'b1, 1'b0, 5'd3, 64'h0000_0000_0000_2000, 32'h0000_3003, 64'd0,
                     64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 8);
        vecs[3].w[0] = 32'h031A_0008; vecs[3].w[1] = 32'h0000_3003; vecs[3].w[2] = 32'h0000_2000;
        vecs[3].w[3] = 32'h0000_0000; vecs[3].w[4] = 32'h9ABC_DEF0; vecs[3].w[5] = 32'h1234_5678;
        vecs[3].w[6] = 32'h0000_0000; vecs[3].w[7] = 32'h0000_0000;

        arst_ni = 1'b0; trace_ready_i = 1'b1;
        drive_rec(vecs[0]); log_trace_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", trace_valid_o, 1'b0);
        check("rst_last", trace_last_o, 1'b0);
        check("rst_data", trace_data_o, 32'd0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_drop", drop_count_o, 16'd0);
        arst_ni = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 4; i++) begin
            drive_rec(vecs[i]);
            step();
            log_trace_i = 1'b0;
            check($sformatf("lat_valid%0d", i), trace_valid_o, 1'b1);
            collect(40);
            compare_words($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("idle_after%0d", i), idle_o, 1'b1);
        end

        // Back-pressure for five cycles on the PC_HI word of a 10-word record (seq 4)
        vs = vecs[1];
        vs.w[0] = 32'h042F_000A;
        drive_rec(vs);
        step();
        log_trace_i = 1'b0;
        got_q.delete();
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            trace_ready_i = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
            if (c == 3) begin
                hold_d = trace_data_o;
                hold_l = trace_last_o;
            end else if (c > 3 && c <= 8) begin
                check("stall_data", trace_data_o, hold_d);
                check("stall_last", trace_last_o, hold_l);
                check("stall_valid", trace_valid_o, 1'b1);
            end
            if (trace_valid_o && trace_ready_i) begin
                got_q.push_back(trace_data_o);
                if (trace_last_o) done = 1'b1;
            end
            step();
        end
        trace_ready_i = 1'b1;
        compare_words("stall", vs);

        // Six strobes into a stalled 4-deep FIFO: seq 5..8 kept, two dropped
        trace_ready_i = 1'b0;
        for (int j = 0; j < 6; j++) begin
            plain_rec(64'h100 + 64'(j));
            step();
        end
        log_trace_i = 1'b0;
        check("drop_count", drop_count_o, 16'd2);
        check("full_head", trace_data_o, 32'h0500_0004);
        // Drain; a new strobe coincides with the first record's last-word handshake
        trace_ready_i = 1'b1;
        got_q.delete();
        bubbles = 0;
        for (int c = 0; c < 100 && got_q.size() < 20; c++) begin
            log_trace_i = 1'b0;
            if (trace_valid_o && trace_last_o && got_q.size() == 3) plain_rec(64'h106);
            if (trace_valid_o) got_q.push_back(trace_data_o);
            else bubbles++;
            step();
        end
        log_trace_i = 1'b0;
        check("pushpop_drop", drop_count_o, 16'd2);
        check("drain_bubbles", 64'(bubbles), 64'd0);
        check("drain_nwords", 64'(got_q.size()), 64'd20);
        exp_pc = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h106};
        for (int r = 0; r < 5 && got_q.size() == 20; r++) begin
            check($sformatf("drain_hdr%0d", r), got_q[4*r],
                  {32'd0, 8'(5 + r), 8'h00, (r == 4) ? 16'h8004 : 16'h0004});
            check($sformatf("drain_pc%0d", r), got_q[4*r+2], exp_pc[r]);
        end
        check("drain_idle", idle_o, 1'b1);
        plain_rec(64'h200);
        step();
        log_trace_i = 1'b0;
        collect(20);
        check("after_drop_hdr", (got_q.size() > 0) ? {32'd0, got_q[0]} : 64'hx, 64'h0A00_0004);

        // 300 records, one every fourth cycle: seq 11.. wraps through 255 -> 0 with no gaps
        words = 0; bubbles = 0; last_err = 0;
        for (int c = 0; c < 1400 && words < 1200; c++) begin
            log_trace_i = 1'b0;
            if ((c % 4 == 0) && (c / 4 < 300)) plain_rec(64'(c / 4));
            if (trace_valid_o) begin
                if (words % 4 == 0)
                    check("b2b_hdr", trace_data_o, {8'(11 + words / 4), 20'h00000, 4'h4});
                if (trace_last_o != (words % 4 == 3)) last_err++;
                words++;
            end else if (words > 0) begin
                bubbles++;
            end
            step();
        end
        log_trace_i = 1'b0;
        check("b2b_words", 64'(words), 64'd1200);
        check("b2b_bubbles", 64'(bubbles), 64'd0);
        check("b2b_last", 64'(last_err), 64'd0);
        check("b2b_drop", drop_count_o, 16'd2);
        check("b2b_idle", idle_o, 1'b1);

        // Reset in the middle of a 10-word burst
        drive_rec(vecs[1]);
        step();
        log_trace_i = 1'b0;
        repeat (3) step();
        check("mid_valid_pre", trace_valid_o, 1'b1);
        arst_ni = 1'b0;
        #1;
        check("arst_valid", trace_valid_o, 1'b0);
        check("arst_last", trace_last_o, 1'b0);
        check("arst_data", trace_data_o, 32'd0);
        check("arst_drop", drop_count_o, 16'd0);
        repeat (3) @(negedge clk_i);
        arst_ni = 1'b1;
        repeat (3) step();
        check("post_rst_idle", idle_o, 1'b1);
        check("post_rst_valid", trace_valid_o, 1'b0);
        check("post_rst_drop", drop_count_o, 16'd0);
        drive_rec(vecs[0]);
        step();
        log_trace_i = 1'b0;
        collect(20);
        compare_words("post_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
